// File: rtl/decoder_nto2n_seq.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_seq
//
// Registered N-to-2^N one-hot decoder with enable, valid/ready request port
// and three operating modes:
//   mode 00 : static decode, y follows one-hot(sel) with one cycle of latency
//   mode 01 : timed pulse, each accepted request drives one-hot(sel) for HOLD
//             cycles; back-to-back requests give gap-free pulses
//   mode 10 : free-running scan, each output bit held HOLD cycles in turn
//   mode 11 : reserved, treated like en=0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low forces y to zero on the next edge
//   mode       operating mode (see above)
//   sel        select index used by static and pulse modes
//   in_valid   pulse request valid
//   in_ready   pulse request can be accepted this cycle (combinational)
//   y          registered one-hot output, or all zero
//   busy       pulse or scan in progress
//   scan_wrap  high during the last hold cycle of bit 2^N-1 in scan mode
// ---------------------------------------------------------------------------
module decoder_nto2n_seq #(
    parameter int N    = 2,
    parameter int HOLD = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [N-1:0]        sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [(1<<N)-1:0]   y,
    output logic                busy,
    output logic                scan_wrap
);

    localparam int W  = 1 << N;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [N-1:0]  IDX_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATIC,
        S_PULSE,
        S_SCAN
    } state_e;

    state_e          state_q, state_d;
    state_e          target;
    logic [W-1:0]    y_q, y_d;
    logic            busy_q, busy_d;
    logic            wrap_q, wrap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            hold_last;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        onehot = W'(1) << i;
    endfunction

    // Mode the block is being asked to run this cycle.
    always_comb begin
        target = S_IDLE;
        if (en) begin
            case (mode)
                2'b00:   target = S_STATIC;
                2'b01:   target = S_PULSE;
                2'b10:   target = S_SCAN;
                default: target = S_IDLE;
            endcase
        end
    end

    assign hold_last = (cnt_q == HOLD_LAST);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        y_d      = y_q;
        busy_d   = busy_q;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        in_ready = 1'b0;

        // Disable, reserved mode, or a switch between two active modes:
        // drop everything and spend one cycle in IDLE with y=0. From IDLE
        // the requested mode starts at its initial condition.
        if (target == S_IDLE || (state_q != S_IDLE && target != state_q)) begin
            state_d = S_IDLE;
            y_d     = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (target)
                S_STATIC: begin
                    state_d = S_STATIC;
                    y_d     = onehot(sel);
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end

                S_PULSE: begin
                    state_d = S_PULSE;
                    idx_d   = '0;
                    if (state_q == S_IDLE) begin
                        y_d   = '0;
                        cnt_d = '0;
                    end else begin
                        // Ready when idle or in the final hold cycle, so a
                        // waiting request follows with no zero gap.
                        in_ready = (y_q == '0) || hold_last;
                        if (in_valid && in_ready) begin
                            y_d   = onehot(sel);
                            cnt_d = '0;
                        end else if (y_q != '0) begin
                            if (hold_last) begin
                                y_d   = '0;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                    end
                    busy_d = (y_d != '0);
                end

                S_SCAN: begin
                    state_d = S_SCAN;
                    busy_d  = 1'b1;
                    if (state_q == S_IDLE) begin
                        idx_d = '0;
                        cnt_d = '0;
                    end else if (hold_last) begin
                        idx_d = idx_q + N'(1);
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    y_d    = onehot(idx_d);
                    wrap_d = (idx_d == IDX_LAST) && (cnt_d == HOLD_LAST);
                end

                default: begin
                    state_d = S_IDLE;
                    y_d     = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign y         = y_q;
    assign busy      = busy_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_nto2n_seq
//
// Directed bench for decoder_nto2n_seq with N=2. The main instance uses
// HOLD=3; a second instance with HOLD=1 shares the inputs and is checked
// during the scan sequence.
// ---------------------------------------------------------------------------
module tb_decoder_nto2n_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       in_valid;

    logic       in_ready,  in_ready1;
    logic [3:0] y,         y1;
    logic       busy,      busy1;
    logic       scan_wrap, scan_wrap1;

    int vectors = 0;
    int errors  = 0;

    decoder_nto2n_seq #(.N(2), .HOLD(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .busy      (busy),
        .scan_wrap (scan_wrap)
    );

    decoder_nto2n_seq #(.N(2), .HOLD(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .y         (y1),
        .busy      (busy1),
        .scan_wrap (scan_wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n    = 1'b1;
        en       = 1'b0;
        mode     = 2'b00;
        sel      = 2'd0;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_y",        32'(y),         32'h0);
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_wrap",     32'(scan_wrap), 32'h0);
        check("rst_in_ready", 32'(in_ready),  32'h0);

        // ---------------- static decode ----------------
        rst_n = 1'b1;
        en    = 1'b1;
        mode  = 2'b00;
        sel   = 2'd0;
        tick();
        check("static_sel0", 32'(y), 32'h1);
        sel = 2'd1;
        check("static_latency", 32'(y), 32'h1);
        tick();
        check("static_sel1", 32'(y), 32'h2);
        sel = 2'd2;
        tick();
        check("static_sel2", 32'(y), 32'h4);
        sel = 2'd3;
        tick();
        check("static_sel3", 32'(y), 32'h8);
        check("static_busy", 32'(busy), 32'h0);
        check("static_in_ready", 32'(in_ready), 32'h0);
        en = 1'b0;
        tick();
        check("en_low_y", 32'(y), 32'h0);

        // ---------------- pulse mode ----------------
        en   = 1'b1;
        mode = 2'b01;
        tick();
        check("pulse_idle_y", 32'(y), 32'h0);
        check("pulse_idle_ready", 32'(in_ready), 32'h1);
        sel      = 2'd2;
        in_valid = 1'b1;
        tick();                                   // request sel=2 accepted
        check("pulse_a_y0", 32'(y), 32'h4);
        check("pulse_a_busy", 32'(busy), 32'h1);
        check("pulse_a_ready0", 32'(in_ready), 32'h0);
        sel = 2'd1;                               // second request held
        tick();
        check("pulse_a_y1", 32'(y), 32'h4);
        check("pulse_a_ready1", 32'(in_ready), 32'h0);
        tick();
        check("pulse_a_y2", 32'(y), 32'h4);
        check("pulse_a_ready2", 32'(in_ready), 32'h1);
        tick();                                   // request sel=1 accepted
        in_valid = 1'b0;
        check("pulse_b_y0", 32'(y), 32'h2);
        check("pulse_b_busy", 32'(busy), 32'h1);
        tick();
        check("pulse_b_y1", 32'(y), 32'h2);
        tick();
        check("pulse_b_y2", 32'(y), 32'h2);
        check("pulse_b_ready2", 32'(in_ready), 32'h1);
        tick();
        check("pulse_end_y", 32'(y), 32'h0);
        check("pulse_end_busy", 32'(busy), 32'h0);

        // ---------------- abort pulse -> static ----------------
        sel      = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_pulse_y", 32'(y), 32'h8);
        mode = 2'b00;
        sel  = 2'd0;
        tick();
        check("abort_gap_y", 32'(y), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        tick();
        check("abort_static_y", 32'(y), 32'h1);

        // ---------------- scan mode ----------------
        mode = 2'b10;
        tick();
        check("scan_abort_y",  32'(y),  32'h0);
        check("scan_abort_y1", 32'(y1), 32'h0);
        for (int t = 0; t < 20; t++) begin
            tick();
            check($sformatf("scan3_y_t%0d", t), 32'(y),
                  32'(1) << ((t / 3) % 4));
            check($sformatf("scan3_wrap_t%0d", t), 32'(scan_wrap),
                  32'(((t / 3) % 4 == 3) && (t % 3 == 2)));
            check($sformatf("scan1_y_t%0d", t), 32'(y1), 32'(1) << (t % 4));
            check($sformatf("scan1_wrap_t%0d", t), 32'(scan_wrap1),
                  32'(t % 4 == 3));
            check($sformatf("scan_busy_t%0d", t), 32'(busy), 32'h1);
            check($sformatf("scan_ready_t%0d", t), 32'(in_ready), 32'h0);
        end

        // ---------------- asynchronous reset mid-scan ----------------
        check("pre_reset_y", 32'(y), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y",    32'(y),         32'h0);
        check("async_rst_busy", 32'(busy),      32'h0);
        check("async_rst_wrap", 32'(scan_wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_scan_y",    32'(y),    32'h1);
        check("post_rst_scan_busy", 32'(busy), 32'h1);

        // ---------------- reserved mode ----------------
        mode = 2'b11;
        tick();
        check("reserved_y",    32'(y),    32'h0);
        check("reserved_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
Parameterised, registered N-to-2^N one-hot decoder. It generalises the team's combinational 2:4 decoder by adding an enable, a valid/ready handshake and three operating modes:
- static decode
- timed one-hot pulse
- free-running one-hot scan

It drives chip-select, row-select and LED-strobe style fan-out from a single clocked select source.

Parameters:
N, 2, select width; output width is 2^N (N >= 1)
HOLD, 1, cycles each one-hot output stays asserted in pulse and scan modes (HOLD >= 1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low forces outputs to zero
mode  input  2  00 static, 01 pulse, 10 scan, 11 reserved
sel  input  N  select index (static and pulse modes)
in_valid  input  1  pulse-mode request valid
in_ready  output  1  pulse-mode request accepted when in_valid & in_ready
y  output  2^N  registered one-hot output
busy  output  1  high while a pulse or scan is in progress
scan_wrap  output  1  one-cycle flag in the last cycle of output bit 2^N-1 in scan mode

Behaviour:
- Reset (rst_n low, asynchronous):
  - y=0, busy=0, scan_wrap=0
  - state=IDLE, hold counter=0, scan index=0
  - in_ready=0 while in reset
- States: IDLE, STATIC, PULSE, SCAN. mode and en are sampled every cycle.
- en=0 or mode=11:
  - next state IDLE; y=0 next cycle
  - counters cleared
  - in_ready=0, busy=0
- Any mode change aborts the current activity:
  - y=0 for one cycle, counters cleared
  - the new mode starts from its initial condition on the following cycle
  - a pending pulse is dropped without completion
- STATIC (mode=00, en=1):
  - y <= one-hot of sel every cycle; latency 1 cycle from sel to y
  - in_ready=0, busy=0, scan_wrap=0
- PULSE (mode=01, en=1):
  - in_ready (combinational) = 1 when no pulse is active, or when the active pulse is in its final hold cycle.
  - Handshake on edge k when in_valid & in_ready:
    - sel is captured
    - y = one-hot(sel) for cycles k+1 .. k+HOLD, then y=0 unless a new request was accepted
  - Back-to-back requests give contiguous pulses with no zero gap.
  - busy=1 while y is non-zero.
  - in_valid while in_ready=0 is ignored; the requester must hold the request.
- SCAN (mode=10, en=1):
  - First cycle after entry: y=bit 0.
  - Each bit is held HOLD cycles, then advances to the next index.
  - After bit 2^N-1 the index wraps to 0.
  - scan_wrap=1 during the last hold cycle of bit 2^N-1.
  - busy=1 throughout; sel and in_valid are ignored; in_ready=0.
- Widths:
  - hold counter is clog2(HOLD) bits, minimum 1
  - scan index is N bits and wraps naturally
  - exactly one bit of y is high, or none; never more than one

Test Plan:
- N=2, HOLD=3; reset asserted mid-scan with y=0100 -> y=0000, busy=0, scan_wrap=0 immediately (asynchronous); after release in scan mode, y=0001 on the first edge.
- Static mode: sel sweeps 0..3, one per cycle -> y=0001, 0010, 0100, 1000, each one cycle after the sel change; en=0 -> y=0000 next cycle.
- Pulse mode: request sel=2 at edge k -> y=0100 at k+1..k+3, busy=1, in_ready=1 only at k+3; a second request sel=1 at k+3 -> y=0010 at k+4..k+6 with no gap.
- Pulse mode: in_valid held while in_ready=0 -> no acceptance until the final hold cycle; no double pulse and no dropped request.
- Scan mode, HOLD=1: y cycles 0001, 0010, 0100, 1000, 0001; scan_wrap=1 exactly in the 1000 cycle; with HOLD=3, scan_wrap asserts only in the third 1000 cycle.
- Mode change from pulse (mid-hold, y=1000) to static sel=0 -> one cycle y=0000, then y=0001; busy drops with the abort.
